// File: rtl/romarb.sv
// romarb: round-robin PRG/CHR ROM fetch arbiter onto a single external byte-read port.
// Define ROMARB_CACHE_EN to add a per-channel last-address hit cache.
module romarb #(
  parameter int ADDRW = 22,
  parameter logic [ADDRW-1:0] CHRBASE = 22'h200000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [20:0]      promaddr,
  input  logic             promreq,
  output logic             promack,
  output logic [7:0]       promdata,
  input  logic [20:0]      cromaddr,
  input  logic             cromreq,
  output logic             cromack,
  output logic [7:0]       cromdata,
  output logic [ADDRW-1:0] extaddr,
  output logic             extreq,
  input  logic             extack,
  input  logic [7:0]       extdata
);
  typedef enum logic [1:0] {IDLE, PRG, CHR, DONE} state_t;
  state_t state_q, state_d;
  logic last_chr_q, last_chr_d;
  logic extreq_q, extreq_d;
  logic [ADDRW-1:0] extaddr_q, extaddr_d;
  logic promack_q, promack_d, cromack_q, cromack_d;
  logic [7:0] promdata_q, promdata_d, cromdata_q, cromdata_d;
  logic pick_chr, hit, fin;
  assign pick_chr = cromreq && (!promreq || !last_chr_q);
  // a grant without extreq is a cache hit and completes one cycle later, like a zero-wait miss
  assign fin = extack || !extreq_q;
`ifdef ROMARB_CACHE_EN
  logic [20:0] ptag_q, ptag_d, ctag_q, ctag_d;
  logic pvalid_q, pvalid_d, cvalid_q, cvalid_d;
  logic pfill, cfill;
  assign pfill = state_q == PRG && extreq_q && extack;
  assign cfill = state_q == CHR && extreq_q && extack;
  assign hit = pick_chr ? cvalid_q && ctag_q == cromaddr : pvalid_q && ptag_q == promaddr;
  always_comb begin
    ptag_d = pfill ? promaddr : ptag_q;
    ctag_d = cfill ? cromaddr : ctag_q;
    pvalid_d = pvalid_q || pfill;
    cvalid_d = cvalid_q || cfill;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptag_q <= '0;
      ctag_q <= '0;
      pvalid_q <= 1'b0;
      cvalid_q <= 1'b0;
    end else begin
      ptag_q <= ptag_d;
      ctag_q <= ctag_d;
      pvalid_q <= pvalid_d;
      cvalid_q <= cvalid_d;
    end
  end
`else
  assign hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    last_chr_d = last_chr_q;
    extaddr_d = extaddr_q;
    extreq_d = extreq_q;
    promack_d = 1'b0;
    cromack_d = 1'b0;
    promdata_d = promdata_q;
    cromdata_d = cromdata_q;
    case (state_q)
      IDLE: if (promreq || cromreq) begin
        state_d = pick_chr ? CHR : PRG;
        extaddr_d = pick_chr ? CHRBASE + ADDRW'(cromaddr) : ADDRW'(promaddr);
        extreq_d = !hit;
      end
      PRG: if (fin) begin
        state_d = DONE;
        extreq_d = 1'b0;
        last_chr_d = 1'b0;
        promack_d = 1'b1;
        promdata_d = extreq_q ? extdata : promdata_q;
      end
      CHR: if (fin) begin
        state_d = DONE;
        extreq_d = 1'b0;
        last_chr_d = 1'b1;
        cromack_d = 1'b1;
        cromdata_d = extreq_q ? extdata : cromdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_chr_q <= 1'b1;
      extaddr_q <= '0;
      extreq_q <= 1'b0;
      promack_q <= 1'b0;
      cromack_q <= 1'b0;
      promdata_q <= '0;
      cromdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_chr_q <= last_chr_d;
      extaddr_q <= extaddr_d;
      extreq_q <= extreq_d;
      promack_q <= promack_d;
      cromack_q <= cromack_d;
      promdata_q <= promdata_d;
      cromdata_q <= cromdata_d;
    end
  end
  assign promack = promack_q;
  assign cromack = cromack_q;
  assign promdata = promdata_q;
  assign cromdata = cromdata_q;
  assign extaddr = extaddr_q;
  assign extreq = extreq_q;
endmodule

// File: tb/tb_romarb.sv
// tb_romarb: directed self-checking bench for romarb (cache steps only when ROMARB_CACHE_EN is defined).
module tb_romarb;
  logic clk = 0, reset = 1;
  logic [20:0] promaddr = '0, cromaddr = '0;
  logic promreq = 0, cromreq = 0, extack = 0;
  logic [7:0] extdata = '0;
  logic promack, cromack, extreq;
  logic [7:0] promdata, cromdata;
  logic [21:0] extaddr;
  int errors = 0, checks = 0;
  logic last_chr = 1;
  logic [7:0] pd_exp = '0, cd_exp = '0;

  romarb dut (
    .clk(clk), .reset(reset),
    .promaddr(promaddr), .promreq(promreq), .promack(promack), .promdata(promdata),
    .cromaddr(cromaddr), .cromreq(cromreq), .cromack(cromack), .cromdata(cromdata),
    .extaddr(extaddr), .extreq(extreq), .extack(extack), .extdata(extdata)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1;
    promreq = 0;
    cromreq = 0;
    cyc;
    cyc;
    reset = 0;
    last_chr = 1;
    pd_exp = '0;
    cd_exp = '0;
  endtask

  // single-channel miss; extack lands w cycles after extreq first shows
  task automatic xact(input logic chr, input logic [20:0] a, input logic [21:0] ea,
                      input int w, input logic [7:0] d);
    if (chr) begin cromaddr = a; cromreq = 1; end else begin promaddr = a; promreq = 1; end
    cyc;
    chk("x_req", 32'(extreq), 1);
    chk("x_addr", 32'(extaddr), 32'(ea));
    repeat (w) cyc;
    chk("x_wait_noack", 32'(promack | cromack), 0);
    extack = 1;
    extdata = d;
    cyc;
    extack = 0;
    extdata = '0;
    if (chr) cd_exp = d; else pd_exp = d;
    chk("x_ack", 32'(chr ? cromack : promack), 1);
    chk("x_other_ack", 32'(chr ? promack : cromack), 0);
    chk("x_data", 32'(chr ? cromdata : promdata), 32'(d));
    chk("x_req_drop", 32'(extreq), 0);
    last_chr = chr;
    cyc;
    if (chr) cromreq = 0; else promreq = 0;
    chk("x_ack_pulse", 32'(promack | cromack), 0);
    cyc;
    chk("x_no_regrant", 32'(extreq), 0);
  endtask

  // both channels raised together, zero-wait memory; winner is the channel not served last
  task automatic pair(input logic [20:0] pa, input logic [20:0] ca, input logic [7:0] dp,
                      input logic [7:0] dc);
    logic fc;
    logic [21:0] pea, cea;
    fc = !last_chr;
    pea = {1'b0, pa};
    cea = 22'h200000 | {1'b0, ca};
    promaddr = pa;
    cromaddr = ca;
    promreq = 1;
    cromreq = 1;
    cyc;
    chk("p1_req", 32'(extreq), 1);
    chk("p1_addr", 32'(extaddr), 32'(fc ? cea : pea));
    extack = 1;
    extdata = fc ? dc : dp;
    cyc;
    extack = 0;
    chk("p1_ack", 32'(fc ? cromack : promack), 1);
    chk("p1_other", 32'(fc ? promack : cromack), 0);
    chk("p1_data", 32'(fc ? cromdata : promdata), 32'(fc ? dc : dp));
    cyc;
    if (fc) cromreq = 0; else promreq = 0;
    chk("p_between", 32'(extreq), 0);
    cyc;
    chk("p2_req", 32'(extreq), 1);
    chk("p2_addr", 32'(extaddr), 32'(fc ? pea : cea));
    extack = 1;
    extdata = fc ? dp : dc;
    cyc;
    extack = 0;
    chk("p2_ack", 32'(fc ? promack : cromack), 1);
    chk("p2_other", 32'(fc ? cromack : promack), 0);
    chk("p2_data", 32'(fc ? promdata : cromdata), 32'(fc ? dp : dc));
    pd_exp = dp;
    cd_exp = dc;
    last_chr = !fc;
    cyc;
    if (fc) promreq = 0; else cromreq = 0;
    cyc;
  endtask

  initial begin
    do_reset;
    chk("rst_promack", 32'(promack), 0);
    chk("rst_cromack", 32'(cromack), 0);
    chk("rst_promdata", 32'(promdata), 0);
    chk("rst_cromdata", 32'(cromdata), 0);
    chk("rst_extreq", 32'(extreq), 0);
    chk("rst_extaddr", 32'(extaddr), 0);
    xact(0, 21'h01234, 22'h001234, 3, 8'hA5);
    xact(1, 21'h00400, 22'h200400, 1, 8'h3C);
    chk("chr_promdata_kept", 32'(promdata), 32'h00A5);
    extack = 1;
    extdata = 8'h99;
    cyc;
    extack = 0;
    chk("stray_promack", 32'(promack), 0);
    chk("stray_cromack", 32'(cromack), 0);
    chk("stray_promdata", 32'(promdata), 32'(pd_exp));
    chk("stray_cromdata", 32'(cromdata), 32'(cd_exp));
    chk("stray_extreq", 32'(extreq), 0);
    do_reset;
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 1) xact(0, 21'h00020 + 21'(i), 22'h000020 + 22'(i), 0, 8'h10 + 8'(i));
      else if (i % 3 == 2) xact(1, 21'h00030 + 21'(i), 22'h200030 + 22'(i), 0, 8'h20 + 8'(i));
      pair(21'h0A000 + 21'(i), 21'h01F00 + 21'(i), 8'h40 + 8'(i), 8'h80 + 8'(i));
    end
    promaddr = 21'h00555;
    promreq = 1;
    cyc;
    chk("abort_req", 32'(extreq), 1);
    reset = 1;
    promreq = 0;
    cyc;
    reset = 0;
    last_chr = 1;
    pd_exp = '0;
    cd_exp = '0;
    chk("abort_extreq", 32'(extreq), 0);
    chk("abort_promack", 32'(promack), 0);
    cyc;
    cyc;
    extack = 1;
    extdata = 8'hEE;
    cyc;
    extack = 0;
    chk("late_promack", 32'(promack), 0);
    chk("late_cromack", 32'(cromack), 0);
    chk("late_extreq", 32'(extreq), 0);
    chk("late_promdata", 32'(promdata), 32'(pd_exp));
    cyc;
    xact(0, 21'h00556, 22'h000556, 2, 8'h5A);
`ifdef ROMARB_CACHE_EN
    xact(0, 21'h00010, 22'h000010, 1, 8'h77);
    promaddr = 21'h00010;
    promreq = 1;
    cyc;
    chk("hit_no_extreq1", 32'(extreq), 0);
    chk("hit_early_ack", 32'(promack), 0);
    cyc;
    chk("hit_no_extreq2", 32'(extreq), 0);
    chk("hit_ack", 32'(promack), 1);
    chk("hit_data", 32'(promdata), 32'h0077);
    cyc;
    promreq = 0;
    cyc;
    xact(0, 21'h00011, 22'h000011, 0, 8'h78);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
